// File: rtl/snn_config_loader_pkg.sv
// Shared definitions for the SNN configuration loader.
//   - loader FSM state encoding
//   - frame header byte, register-file size and inter-byte timeout
//   - network register-map addresses
//   - helper for the 9-bit frame range check
package snn_config_loader_pkg;

   localparam logic [7:0] HEADER     = 8'hA5;
   localparam int         NUM_PARAMS = 15;
   localparam int         TIMEOUT    = 255;
   localparam int         ADDR_W     = 4;
   localparam int         DATA_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN    = 3'd1,
      ST_BASE   = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_COMMIT = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   // Network register map
   localparam logic [ADDR_W-1:0] ADDR_THRESHOLD     = 4'd0;
   localparam logic [ADDR_W-1:0] ADDR_LEAK_RATE     = 4'd1;
   localparam logic [ADDR_W-1:0] ADDR_REFRAC_PERIOD = 4'd2;
   localparam logic [ADDR_W-1:0] ADDR_FIRST_W0      = 4'd3;
   localparam logic [ADDR_W-1:0] ADDR_FIRST_W1      = 4'd4;
   localparam logic [ADDR_W-1:0] ADDR_FIRST_W2      = 4'd5;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W0     = 4'd6;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W1     = 4'd7;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W2     = 4'd8;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W3     = 4'd9;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W4     = 4'd10;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W5     = 4'd11;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W6     = 4'd12;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W7     = 4'd13;
   localparam logic [ADDR_W-1:0] ADDR_SECOND_W8     = 4'd14;

   // True when a frame of 'len' bytes starting at 'base' fits in a register
   // file of 'num' entries. Done at 9 bits so base=255 cannot wrap into range.
   function automatic logic frame_fits(input logic [7:0] base,
                                       input logic [3:0] len,
                                       input int         num);
      logic [8:0] span;
      span = {1'b0, base} + {5'd0, len};
      return span <= 9'(num);
   endfunction

endpackage

// File: rtl/snn_cfg_buffer.sv
// Staging buffer for frame payload bytes. Payload is held here until the
// checksum has been verified, then replayed to the network register file.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index (combinational read)
//   rdata  - read data; zero for indices beyond DEPTH-1
// Contents are not reset.
module snn_cfg_buffer
   import snn_config_loader_pkg::*;
#(
   parameter int DEPTH = NUM_PARAMS,
   parameter int AW    = ADDR_W,
   parameter int DW    = DATA_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (int'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   // The commit sequencer briefly parks the read index one past the last
   // entry; return zero there rather than reading out of range.
   assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/snn_config_loader.sv
// Byte-stream configuration loader for a small spiking network.
// Receives frames  HEADER, LEN, BASE, LEN data bytes, CSUM  (CSUM = XOR of
// LEN, BASE and data), stages the payload, and only after the checksum
// matches replays it as LEN consecutive register-file writes. The network is
// frozen (run=0, spikes gated off) from the moment a frame header is accepted
// until a frame commits successfully.
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high; byte_data must be stable while byte_valid is
// high and not yet accepted. byte_ready is low only while committing or
// reporting an error.
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   byte_valid     - input byte strobe
//   byte_data      - input byte
//   byte_ready     - loader can accept a byte this cycle
//   cfg_addr       - register-file address to the network
//   cfg_data       - register-file data to the network
//   cfg_we         - register-file write enable (high only while committing)
//   spikes_in      - raw input spikes
//   spikes_gated   - spikes_in masked by run
//   run            - network configured and running
//   cfg_error      - sticky frame-error flag, cleared by a good frame
module snn_config_loader
   import snn_config_loader_pkg::*;
#(
   parameter logic [7:0] HEADER     = snn_config_loader_pkg::HEADER,
   parameter int         NUM_PARAMS = snn_config_loader_pkg::NUM_PARAMS,
   parameter int         TIMEOUT    = snn_config_loader_pkg::TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic [3:0] cfg_addr,
   output logic [7:0] cfg_data,
   output logic       cfg_we,
   input  logic [2:0] spikes_in,
   output logic [2:0] spikes_gated,
   output logic       run,
   output logic       cfg_error
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_e           state;
   logic [3:0]       len_q;
   logic [7:0]       base_q;
   logic [7:0]       csum_q;
   logic [3:0]       cnt_q;   // payload index while receiving and committing
   logic [TMR_W-1:0] tmr_q;

   logic             xfer;
   logic             in_frame;
   logic             buf_we;
   logic [7:0]       buf_rdata;

   assign byte_ready   = (state != ST_COMMIT) && (state != ST_ERR);
   assign xfer         = byte_valid && byte_ready;
   assign in_frame     = (state == ST_LEN) || (state == ST_BASE) ||
                         (state == ST_DATA) || (state == ST_CSUM);
   assign buf_we       = (state == ST_DATA) && xfer;
   assign spikes_gated = spikes_in & {3{run}};

   snn_cfg_buffer #(
      .DEPTH (NUM_PARAMS),
      .AW    (4),
      .DW    (8)
   ) u_buffer (
      .clk   (clk),
      .we    (buf_we),
      .waddr (cnt_q),
      .wdata (byte_data),
      .raddr (cnt_q),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         run       <= 1'b0;
         cfg_error <= 1'b0;
         cfg_we    <= 1'b0;
         cfg_addr  <= '0;
         cfg_data  <= '0;
         len_q     <= '0;
         base_q    <= '0;
         csum_q    <= '0;
         cnt_q     <= '0;
         tmr_q     <= '0;
      end else begin
         cfg_we <= 1'b0;

         if (in_frame && !xfer) begin
            tmr_q <= tmr_q + TMR_W'(1);
         end else begin
            tmr_q <= '0;
         end

         case (state)
            ST_IDLE: begin
               cnt_q <= '0;
               if (xfer && (byte_data == HEADER)) begin
                  run   <= 1'b0;
                  state <= ST_LEN;
               end
            end

            ST_LEN: begin
               if (xfer) begin
                  if ((byte_data == 8'd0) || (int'(byte_data) > NUM_PARAMS)) begin
                     state <= ST_ERR;
                  end else begin
                     len_q  <= byte_data[3:0];
                     csum_q <= byte_data;
                     state  <= ST_BASE;
                  end
               end
            end

            ST_BASE: begin
               if (xfer) begin
                  if (!frame_fits(byte_data, len_q, NUM_PARAMS)) begin
                     state <= ST_ERR;
                  end else begin
                     base_q <= byte_data;
                     csum_q <= csum_q ^ byte_data;
                     cnt_q  <= '0;
                     state  <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (xfer) begin
                  csum_q <= csum_q ^ byte_data;
                  if (cnt_q == len_q - 4'd1) begin
                     cnt_q <= '0;
                     state <= ST_CSUM;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end

            ST_CSUM: begin
               if (xfer) begin
                  if (byte_data == csum_q) begin
                     // First write is issued on entry so cfg_we is high for
                     // exactly the LEN cycles spent in COMMIT.
                     cfg_we   <= 1'b1;
                     cfg_addr <= 4'(base_q + 8'(cnt_q));
                     cfg_data <= buf_rdata;
                     cnt_q    <= 4'd1;
                     state    <= ST_COMMIT;
                  end else begin
                     state <= ST_ERR;
                  end
               end
            end

            ST_COMMIT: begin
               if (cnt_q == len_q) begin
                  run       <= 1'b1;
                  cfg_error <= 1'b0;
                  cnt_q     <= '0;
                  state     <= ST_IDLE;
               end else begin
                  cfg_we   <= 1'b1;
                  cfg_addr <= 4'(base_q + 8'(cnt_q));
                  cfg_data <= buf_rdata;
                  cnt_q    <= cnt_q + 4'd1;
               end
            end

            ST_ERR: begin
               cfg_error <= 1'b1;
               run       <= 1'b0;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase

         // Inter-byte timeout overrides the receive states when no byte moved.
         if (in_frame && !xfer && (tmr_q == TMR_W'(TIMEOUT - 1))) begin
            state <= ST_ERR;
         end
      end
   end

endmodule

// File: doc/snn_config_loader.md
SNN_CONFIG_LOADER -- requirements
Module: snn_config_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- HEADER, 8'hA5, frame start byte.
- NUM_PARAMS, 15, size of the network register file (addresses 0..14).
- TIMEOUT, 255, idle cycles allowed between bytes inside a frame.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- byte_valid  in  1  input byte strobe.
- byte_data  in  8  input byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- cfg_addr  out  4  register-file address to the network.
- cfg_data  out  8  register-file data to the network.
- cfg_we  out  1  register-file write enable to the network.
- spikes_in  in  3  raw input spikes.
- spikes_gated  out  3  spikes forwarded to the network.
- run  out  1  network configured and running.
- cfg_error  out  1  sticky frame-error flag.

Function
REQ-003 A byte SHALL transfer only in a cycle where byte_valid and byte_ready are both high.
REQ-004 The frame format SHALL be: HEADER, LEN (1..NUM_PARAMS), BASE, LEN data bytes, CSUM.
REQ-005 CSUM SHALL be the XOR of LEN, BASE and all data bytes.
REQ-006 The FSM SHALL have the states IDLE, LEN, BASE, DATA, CSUM, COMMIT and ERR.
REQ-007 In IDLE, a byte equal to HEADER SHALL move the FSM to LEN; any other byte SHALL be discarded with no error.
REQ-008 In LEN, LEN=0 or LEN>NUM_PARAMS SHALL move the FSM to ERR; otherwise the FSM SHALL latch LEN and move to BASE.
REQ-009 In BASE, BASE+LEN>NUM_PARAMS SHALL move the FSM to ERR; otherwise the FSM SHALL latch BASE and move to DATA.
REQ-010 In DATA, each data byte SHALL be stored into a 15x8 buffer at index 0..LEN-1; after the LEN-th byte the FSM SHALL move to CSUM.
REQ-011 In CSUM, a checksum match SHALL move the FSM to COMMIT; a mismatch SHALL move it to ERR.
REQ-012 The network registers SHALL NOT be written before the checksum has been verified.
REQ-013 COMMIT SHALL issue exactly LEN consecutive writes, one per cycle: cfg_we=1, cfg_addr=BASE+k, cfg_data=buffer[k], for k=0..LEN-1.
REQ-014 After the last write, the FSM SHALL set run=1, clear cfg_error and return to IDLE.
REQ-015 byte_ready SHALL be 1 in IDLE, LEN, BASE, DATA and CSUM, and 0 in COMMIT and ERR.
REQ-016 cfg_we SHALL be 0 outside COMMIT.
REQ-017 run SHALL drop to 0 on the cycle the FSM leaves IDLE with a valid HEADER, so the network is frozen during reprogramming.
REQ-018 spikes_gated SHALL equal spikes_in AND {3{run}}, combinationally.
REQ-019 ERR SHALL last exactly one cycle, set cfg_error=1, leave run=0 and return to IDLE.
REQ-020 A timeout counter SHALL count cycles without a transfer while in LEN, BASE, DATA or CSUM; when it reaches TIMEOUT the FSM SHALL move to ERR.
REQ-021 The timeout counter SHALL clear on every transfer and in IDLE.
REQ-022 A HEADER byte arriving mid-frame SHALL be treated as ordinary frame data, not as a restart.
REQ-023 Checksum and address arithmetic SHALL be 8-bit; the range check in REQ-009 SHALL be done at 9-bit width so that BASE=255 is rejected.

Reset
REQ-024 On reset, the FSM SHALL enter IDLE and the following outputs SHALL go low: run, cfg_error, cfg_we, cfg_addr, cfg_data.
REQ-025 On reset, the timeout counter and all latched LEN, BASE and CSUM values SHALL clear.
REQ-026 A reset during COMMIT SHALL abort the remaining writes immediately; registers already written are not rolled back.
REQ-027 Buffer contents need not be reset.

Structure
REQ-028 A shared package SHALL hold: the FSM state enum, HEADER, NUM_PARAMS, and the register-map address constants 0..14 (THRESHOLD=0, LEAK_RATE=1, REFRAC_PERIOD=2, FIRST_W0..2=3..5, SECOND_W=6..14).
REQ-029 The design SHALL contain one sub-module, snn_cfg_buffer: a 15x8 register array with a write port and a read port.

Verification
REQ-030 The bench SHALL cover the following directed scenarios.
- Good full frame: A5,0F,00, bytes 01..0F, CSUM 0F^00^(XOR of 01..0F) -> 15 writes on consecutive cycles at addr 0..14 carrying data 01..0F; run=1; cfg_error=0.
- Bad checksum: A5,02,03,11,22,00 -> no cfg_we pulses; cfg_error=1; run=0.
- Range error: A5,03,0D -> ERR immediately after BASE; no writes.
- Timeout: A5,01, then 255 idle cycles -> cfg_error=1 and FSM back in IDLE.
- Run gating: spikes_in=3'b111 before and after a good frame -> spikes_gated=000 before, 111 after.
- Reset mid-COMMIT, plus an IDLE garbage byte 3C: reset on the 2nd write cycle -> cfg_we=0 on the next cycle and run=0; the 3C byte is ignored with cfg_error unchanged.
